cpu_mdu: RTL and testbench
==========================

CPU_MDU -- requirements
Module: cpu_mdu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width (legal 8..64, even).
REQ-002 The block SHALL have parameter MUL_STAGES, default 2, giving the multiply latency in cycles (legal 1..4).
REQ-003 Port clock  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is the reset; reset SHALL be synchronous and active-high.
REQ-005 Port p3_start  input  1  launches an operation when sampled high while not busy.
REQ-006 Port p3_func  input  3  selects the operation: 000 MUL (low), 001 MULHS, 010 MULHU, 100 DIVU, 101 DIVS, 110 MODU, 111 MODS; 011 is reserved.
REQ-007 Ports p3_data_a and p3_data_b  input  WIDTH  are the operands (a = multiplicand/dividend).
REQ-008 Port p4_kill  input  1  aborts the operation in flight (previous-instruction jump).
REQ-009 Port busy  output  1  is high from the cycle after start acceptance until done is asserted.
REQ-010 Port done  output  1  is a one-cycle pulse that marks result as valid.
REQ-011 Port result  output  WIDTH  is the operation result.
REQ-012 Port div_by_zero  output  1  is valid with done; high for DIV*/MOD* with b == 0.

Function
REQ-013 The block SHALL accept start only in IDLE; start while busy SHALL be ignored, with no effect on operands or function.
REQ-014 The block SHALL latch operands and function on the acceptance edge; input changes after acceptance SHALL have no effect.
REQ-015 The state machine SHALL have states IDLE, MUL, DIV and FIX: IDLE->MUL on a multiply start, IDLE->DIV on a divide start, MUL->IDLE after MUL_STAGES cycles, DIV->FIX after WIDTH iterations, FIX->IDLE.
REQ-016 Multiply: the block SHALL form the 2*WIDTH product; MUL returns the low WIDTH bits, MULHS the high WIDTH bits with both operands signed, MULHU the high WIDTH bits with both operands unsigned.
REQ-017 Multiply: done SHALL be high in exactly the cycle following the MUL_STAGES-th rising edge after acceptance.
REQ-018 Divide: the block SHALL run a radix-2 restoring divide on operand magnitudes, one quotient bit per cycle; FIX SHALL apply signs (quotient negative iff signs differ, remainder takes the dividend's sign).
REQ-019 Divide: done SHALL be high in the cycle following the (WIDTH+1)-th edge after acceptance, i.e. in the FIX cycle.
REQ-020 Divide by zero: quotient SHALL be all ones, remainder SHALL equal the dividend, and div_by_zero SHALL be 1.
REQ-021 Signed overflow (most-negative / -1): quotient SHALL be the most-negative value, remainder SHALL be 0, and div_by_zero SHALL be 0.
REQ-022 Reserved func 011 SHALL complete as MUL timing with result 0.
REQ-023 p4_kill high in any cycle SHALL force IDLE on the next edge; done SHALL NOT pulse for the killed operation.
REQ-024 If p4_kill and p3_start are both high while IDLE, kill SHALL win and the start SHALL NOT be accepted.
REQ-025 result and div_by_zero SHALL hold their last done value until the next done.
REQ-026 A new start SHALL be accepted in the same cycle that done is high; back-to-back operations are legal.

Reset
REQ-027 Reset SHALL force IDLE, busy=0, done=0, result=0 and div_by_zero=0, overriding any operation in flight, including mid-divide.

Configuration
REQ-028 When macro MDU_EARLY_OUT_EN is defined, a divide whose divisor is zero or whose dividend magnitude is less than the divisor magnitude SHALL skip DIV and go straight to FIX, with done high in the cycle after the first edge after acceptance and results per REQ-018/020.
REQ-029 When MDU_EARLY_OUT_EN is undefined, all divides SHALL take the full latency of REQ-019.

Verification (WIDTH=32, MUL_STAGES=2, macro undefined unless stated)
REQ-030 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done 2 cycles after acceptance; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHS same operands -> 0x00000000.
REQ-031 DIVS 0xFFFFFFF9 / 2 -> 0xFFFFFFFD with done at cycle 33; MODS same operands -> 0xFFFFFFFF.
REQ-032 DIVU 5 / 0 -> 0xFFFFFFFF with div_by_zero=1; MODU 5 / 0 -> 5; DIVS 0x80000000 / 0xFFFFFFFF -> 0x80000000; MODS same operands -> 0.
REQ-033 DIVU started with p4_kill pulsed at cycle 10 -> no done, busy=0 from cycle 11; a new MUL 3 x 4 started then -> 12.
REQ-034 Reset asserted at cycle 20 of a divide -> all outputs 0 on the next cycle; a start on the following cycle is accepted.
REQ-035 With MDU_EARLY_OUT_EN defined: DIVU 3 / 10 -> quotient 0 with done at cycle 1; MODU same operands -> 3.

Source files
------------

// File: rtl/cpu_mdu.sv
// cpu_mdu: multiply/divide unit with a fixed-latency multiply and a radix-2 restoring divide.
// Define MDU_EARLY_OUT_EN to let zero-divisor and small-dividend divides finish after one edge.
module cpu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             p3_start,
  input  logic [2:0]       p3_func,
  input  logic [WIDTH-1:0] p3_data_a,
  input  logic [WIDTH-1:0] p3_data_b,
  input  logic             p4_kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    f_neg = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_fin_mul;
  logic             w_fin_div;
  logic             w_div_last;

  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_func;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_a_neg;
  logic             r_q_neg;
  logic             r_b_zero;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_dbz;

  logic             w_in_a_neg;
  logic             w_in_b_neg;
  logic             w_in_b_zero;
  logic [WIDTH-1:0] w_in_a_mag;
  logic [WIDTH-1:0] w_in_b_mag;
  logic             w_early;

  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_div_res;

  logic [2*WIDTH-1:0] w_prod_u;
  logic [WIDTH-1:0]   w_mulhs;
  logic [WIDTH-1:0]   w_mul_res;

  // Operand preparation: signedness comes from func bit 0 (DIVS/MODS)
  assign w_in_a_neg  = p3_func[0] & p3_data_a[WIDTH-1];
  assign w_in_b_neg  = p3_func[0] & p3_data_b[WIDTH-1];
  assign w_in_b_zero = (p3_data_b == {WIDTH{1'b0}});
  assign w_in_a_mag  = w_in_a_neg ? f_neg(p3_data_a) : p3_data_a;
  assign w_in_b_mag  = w_in_b_neg ? f_neg(p3_data_b) : p3_data_b;

`ifdef MDU_EARLY_OUT_EN
  assign w_early = w_in_b_zero | (w_in_a_mag < w_in_b_mag);
`else
  assign w_early = 1'b0;
`endif

  // FIX shares the done cycle, so it must also accept a new start
  assign w_accept   = p3_start & ~p4_kill & ((r_state == S_IDLE) | (r_state == S_FIX));
  assign w_div_last = (r_state == S_DIV) && (r_cnt == CW'(WIDTH));

  // Restoring step: shift in the next dividend bit, subtract when it fits
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

  assign w_q_fix   = r_b_zero ? {WIDTH{1'b1}} : (r_q_neg ? f_neg(r_quo) : r_quo);
  assign w_r_fix   = r_a_neg ? f_neg(r_rem) : r_rem;
  assign w_div_res = r_func[1] ? w_r_fix : w_q_fix;

  // Signed high half derived from the unsigned product by subtracting the sign corrections
  assign w_prod_u = {{WIDTH{1'b0}}, r_op_a} * {{WIDTH{1'b0}}, r_op_b};
  assign w_mulhs  = w_prod_u[2*WIDTH-1:WIDTH]
                  - (r_op_a[WIDTH-1] ? r_op_b : {WIDTH{1'b0}})
                  - (r_op_b[WIDTH-1] ? r_op_a : {WIDTH{1'b0}});

  // Multiply result select; reserved func 011 yields zero
  always_comb begin
    w_mul_res = {WIDTH{1'b0}};
    case (r_func[1:0])
      2'b00:   w_mul_res = w_prod_u[WIDTH-1:0];
      2'b01:   w_mul_res = w_mulhs;
      2'b10:   w_mul_res = w_prod_u[2*WIDTH-1:WIDTH];
      default: w_mul_res = {WIDTH{1'b0}};
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and completion decode; kill overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_fin_mul   = 1'b0;
    w_fin_div   = 1'b0;
    if (p4_kill) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_FIX: begin
          if (w_accept) begin
            w_state_nxt = p3_func[2] ? S_DIV : S_MUL;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_MUL: begin
          if (r_cnt == CW'(MUL_STAGES - 1)) begin
            w_state_nxt = S_IDLE;
            w_fin_mul   = 1'b1;
          end else begin
            w_state_nxt = S_MUL;
          end
        end
        S_DIV: begin
          if (w_div_last) begin
            w_state_nxt = S_FIX;
            w_fin_div   = 1'b1;
          end else begin
            w_state_nxt = S_DIV;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand latch and iteration datapath; early-out preloads the counter to its final value
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= {CW{1'b0}};
      r_func   <= 3'b000;
      r_op_a   <= {WIDTH{1'b0}};
      r_op_b   <= {WIDTH{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_dvs    <= {WIDTH{1'b0}};
      r_a_neg  <= 1'b0;
      r_q_neg  <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (w_accept) begin
      r_func   <= p3_func;
      r_op_a   <= p3_data_a;
      r_op_b   <= p3_data_b;
      r_dvs    <= w_in_b_mag;
      r_a_neg  <= w_in_a_neg;
      r_q_neg  <= w_in_a_neg ^ w_in_b_neg;
      r_b_zero <= w_in_b_zero;
      if (p3_func[2] && w_early) begin
        r_cnt <= CW'(WIDTH);
        r_rem <= w_in_a_mag;
        r_quo <= {WIDTH{1'b0}};
      end else begin
        r_cnt <= {CW{1'b0}};
        r_rem <= {WIDTH{1'b0}};
        r_quo <= w_in_a_mag;
      end
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else if ((r_state == S_DIV) && !w_div_last) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Registered outputs; result and div_by_zero hold between done pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {WIDTH{1'b0}};
      r_dbz    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_MUL) | (w_state_nxt == S_DIV);
      r_done <= w_fin_mul | w_fin_div;
      if (w_fin_mul) begin
        r_result <= w_mul_res;
        r_dbz    <= 1'b0;
      end else if (w_fin_div) begin
        r_result <= w_div_res;
        r_dbz    <= r_b_zero;
      end else begin
        r_result <= r_result;
        r_dbz    <= r_dbz;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_cpu_mdu.sv
// tb_cpu_mdu: directed and lightly randomised scoreboard bench for cpu_mdu (WIDTH=32, MUL_STAGES=2).
module tb_cpu_mdu;

  logic        clock;
  logic        reset;
  logic        p3_start;
  logic [2:0]  p3_func;
  logic [31:0] p3_data_a;
  logic [31:0] p3_data_b;
  logic        p4_kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [2:0] funcs [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

  cpu_mdu #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .p3_start    (p3_start),
    .p3_func     (p3_func),
    .p3_data_a   (p3_data_a),
    .p3_data_b   (p3_data_b),
    .p4_kill     (p4_kill),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model built on the language's own multiply/divide operators
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    logic signed [63:0] ps;
    logic [31:0] r;
    pu = {32'd0, a} * {32'd0, b};
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    r  = 32'd0;
    case (f)
      3'b000: r = pu[31:0];
      3'b001: r = ps[63:32];
      3'b010: r = pu[63:32];
      3'b100: if (b == 32'd0) r = 32'hFFFF_FFFF; else r = a / b;
      3'b110: if (b == 32'd0) r = a; else r = a % b;
      3'b101: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      3'b111: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] am;
    logic [31:0] bm;
    am = (f[0] && a[31]) ? -a : a;
    bm = (f[0] && b[31]) ? -b : b;
    if (f[2] && (b == 32'd0 || am < bm)) return 1;
`endif
    if (!f[2]) return 2;
    return 33;
  endfunction

  // Launch one op, scramble inputs after acceptance, poke a start while busy, then score at done
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    exp_t e;
    int   n;
    bit   seen;
    e.tag = tag;
    e.res = exp_res;
    e.dbz = f[2] && (b == 32'd0);
    e.lat = lat_of(f, a, b);
    sb.push_back(e);
    p3_start = 1'b1; p3_func = f; p3_data_a = a; p3_data_b = b;
    tick();
    p3_start = 1'b0; p3_func = ~f; p3_data_a = ~a; p3_data_b = ~b;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      tick();
      n++;
      if (done) begin
        seen = 1'b1;
      end else if (n == 1) begin
        p3_start = 1'b1; p3_func = 3'b100; p3_data_a = 32'd0; p3_data_b = 32'd0;
      end else begin
        p3_start = 1'b0;
      end
    end
    p3_start = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({e.tag, "_latency"}, 64'(n), 64'(e.lat));
    check({e.tag, "_result"}, {32'd0, result}, {32'd0, e.res});
    check({e.tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
  endtask

  initial begin
    int pulses;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1; p3_start = 1'b0; p3_func = 3'b000;
    p3_data_a = 32'd0; p3_data_b = 32'd0; p4_kill = 1'b0;
    repeat (3) tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;
    tick();

    run_op("mul_7xm3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    repeat (3) tick();
    check("hold_done", {63'd0, done}, 64'd0);
    check("hold_result", {32'd0, result}, 64'h0000_0000_FFFF_FFEB);

    run_op("mulhu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhs_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("divs_m7_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("mods_m7_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("modu_5_0", 3'b110, 32'd5, 32'd0, 32'd5);
    run_op("divs_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("mods_ovf", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("rsvd_011", 3'b011, 32'd9, 32'd9, 32'd0);
    run_op("divs_m9_0", 3'b101, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF);
    run_op("mods_m9_0", 3'b111, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7);
    run_op("divu_3_10", 3'b100, 32'd3, 32'd10, 32'd0);
    run_op("modu_3_10", 3'b110, 32'd3, 32'd10, 32'd3);
    run_op("divu_max", 3'b100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++) begin
      rf = funcs[$urandom_range(0, 6)];
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      run_op($sformatf("rand%0d", i), rf, ra, rb, model(rf, ra, rb));
    end

    // Kill sampled at the tenth edge of a divide: no done, busy drops
    p3_start = 1'b1; p3_func = 3'b100; p3_data_a = 32'd1000; p3_data_b = 32'd3;
    tick();
    p3_start = 1'b0;
    repeat (9) tick();
    p4_kill = 1'b1;
    tick();
    p4_kill = 1'b0;
    check("kill_busy", {63'd0, busy}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check("kill_no_done", 64'(pulses), 64'd0);
    run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12);

    // Kill and start together while idle: start rejected
    p3_start = 1'b1; p4_kill = 1'b1; p3_func = 3'b000; p3_data_a = 32'd5; p3_data_b = 32'd5;
    tick();
    p3_start = 1'b0; p4_kill = 1'b0;
    check("killstart_busy", {63'd0, busy}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) pulses++;
    end
    check("killstart_no_done", 64'(pulses), 64'd0);
    check("killstart_result", {32'd0, result}, 64'd12);

    // Reset sampled at the twentieth edge of a divide
    p3_start = 1'b1; p3_func = 3'b100; p3_data_a = 32'd100; p3_data_b = 32'd7;
    tick();
    p3_start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_result", {32'd0, result}, 64'd0);
    check("midrst_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;
    run_op("post_rst_divu", 3'b100, 32'd100, 32'd7, 32'd14);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
